// File: rtl/bmem_responder.sv
// bmem_responder: banked-memory responder serving 256-bit lines as four 64-bit beats from an internal line array.
// Reads return LATENCY cycles after acceptance, in order; ready drops while the read queue is full and is held high mid-write.
module bmem_responder #(
    parameter int MEM_LINES = 256,
    parameter int LATENCY   = 8,
    parameter int QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        bmem_err
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int QW    = $clog2(QDEPTH);

    localparam logic [QW:0] Q_FULL = (QW+1)'(QDEPTH);
    localparam logic [QW:0] Q_TWO  = (QW+1)'(2);
    // Outputs are registered, so the head must qualify one cycle before its first beat.
    localparam logic [15:0] ELIG   = 16'(LATENCY - 1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_1    = 2'd1,
        W_2    = 2'd2,
        W_3    = 2'd3
    } wstate_t;

    wstate_t wstate;
    wstate_t wstate_next;

    logic [255:0] line_mem [MEM_LINES] = '{default: '0};

    logic [IDX_W-1:0] w_idx;
    logic [63:0]      w_beat0;
    logic [63:0]      w_beat1;
    logic [63:0]      w_beat2;

    logic cap_beat0;
    logic cap_beat1;
    logic cap_beat2;
    logic wr_commit;
    logic rd_accept;
    logic err_set;

    logic [26:0]  q_addr [QDEPTH];
    logic [255:0] q_line [QDEPTH];
    logic [15:0]  q_ts   [QDEPTH];

    logic [QW-1:0] wr_ptr;
    logic [QW-1:0] rd_ptr;
    logic [QW:0]   q_count;
    logic [QW:0]   q_count_next;
    logic          q_push;
    logic          q_pop;

    logic [15:0]  cnt;
    logic [255:0] rd_line;

    logic          ret_busy;
    logic [1:0]    ret_beat;
    logic          last_beat;
    logic [QW-1:0] cand_ptr;
    logic          cand_present;
    logic [15:0]   cand_age;
    logic          ret_start;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bmem_addr[4:0];

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
        end else begin
            wstate <= wstate_next;
        end
    end

    always_comb begin
        wstate_next = wstate;
        case (wstate)
            W_IDLE:  if (bmem_write && bmem_ready) wstate_next = W_1;
            W_1:     if (bmem_write) wstate_next = W_2;
            W_2:     if (bmem_write) wstate_next = W_3;
            W_3:     if (bmem_write) wstate_next = W_IDLE;
            default: wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        cap_beat0 = 1'b0;
        cap_beat1 = 1'b0;
        cap_beat2 = 1'b0;
        wr_commit = 1'b0;
        rd_accept = 1'b0;
        err_set   = 1'b0;
        case (wstate)
            W_IDLE: begin
                cap_beat0 = bmem_write && bmem_ready;
                rd_accept = bmem_read && bmem_ready && !bmem_write;
                err_set   = bmem_read && bmem_write && bmem_ready;
            end
            W_1: begin
                cap_beat1 = bmem_write;
                err_set   = bmem_read || !bmem_write;
            end
            W_2: begin
                cap_beat2 = bmem_write;
                err_set   = bmem_read || !bmem_write;
            end
            W_3: begin
                wr_commit = bmem_write;
                err_set   = bmem_read || !bmem_write;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cap_beat0) begin
            w_idx   <= bmem_addr[5 +: IDX_W];
            w_beat0 <= bmem_wdata;
        end
        if (cap_beat1) w_beat1 <= bmem_wdata;
        if (cap_beat2) w_beat2 <= bmem_wdata;
    end

    // The line only changes on the final beat, so a reset mid-burst leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit) begin
            line_mem[w_idx] <= {bmem_wdata, w_beat2, w_beat1, w_beat0};
        end
    end

    assign rd_line = line_mem[bmem_addr[5 +: IDX_W]];

    // ---------------- read queue ----------------
    assign q_push = rd_accept;
    assign q_pop  = last_beat;

    always_comb begin
        q_count_next = q_count;
        if (q_push && !q_pop) begin
            q_count_next = q_count + (QW+1)'(1);
        end else if (!q_push && q_pop) begin
            q_count_next = q_count - (QW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) begin
            q_addr[wr_ptr] <= bmem_addr[31:5];
            q_line[wr_ptr] <= rd_line;
            q_ts[wr_ptr]   <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (q_push) wr_ptr <= wr_ptr + QW'(1);
            if (q_pop)  rd_ptr <= rd_ptr + QW'(1);
            q_count <= q_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // ---------------- return engine ----------------
    // On the last beat the following entry is already examined so bursts chain with no gap.
    assign last_beat    = ret_busy && (ret_beat == 2'd3);
    assign cand_ptr     = last_beat ? rd_ptr + QW'(1) : rd_ptr;
    assign cand_present = last_beat ? (q_count >= Q_TWO) : (q_count != '0);
    assign cand_age     = cnt - q_ts[cand_ptr];
    assign ret_start    = (!ret_busy || last_beat) && cand_present && (cand_age >= ELIG);

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_busy <= 1'b0;
            ret_beat <= 2'd0;
        end else if (ret_start) begin
            ret_busy <= 1'b1;
            ret_beat <= 2'd0;
        end else if (last_beat) begin
            ret_busy <= 1'b0;
            ret_beat <= 2'd0;
        end else if (ret_busy) begin
            ret_beat <= ret_beat + 2'd1;
        end
    end

    assign bmem_rvalid = ret_busy;
    assign bmem_raddr  = ret_busy ? {q_addr[rd_ptr], 5'b00000} : 32'd0;
    assign bmem_rdata  = ret_busy ? q_line[rd_ptr][{ret_beat, 6'b000000} +: 64] : 64'd0;

    // ---------------- ready / error ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bmem_ready <= 1'b0;
        end else begin
            bmem_ready <= (wstate_next != W_IDLE) || (q_count_next != Q_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bmem_err <= 1'b0;
        end else if (err_set) begin
            bmem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bmem_responder.sv
// Scoreboard bench for bmem_responder: expected beats queued at read acceptance, checked on rvalid.
module tb_bmem_responder;

    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bmem_addr = '0;
    logic        bmem_read = 1'b0;
    logic        bmem_write = 1'b0;
    logic [63:0] bmem_wdata = '0;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        bmem_err;

    bmem_responder #(.MEM_LINES(256), .LATENCY(LAT), .QDEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .bmem_err    (bmem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] line;
        int           acc;
    } exp_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    exp_t         sb[$];
    exp_t         cur;
    int           mbeat = 0;
    bit           in_burst = 1'b0;
    int           last_end = -100;
    int           mws = 0;
    logic [7:0]   widx = '0;
    logic [63:0]  wb[3];
    logic [255:0] mmem[256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: output checks against the scoreboard, then the reference write/read model.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            in_burst = 1'b0;
            mws      = 0;
            last_end = -100;
        end else begin
            if (bmem_rvalid) begin
                if (!in_burst) begin
                    if (sb.size() == 0) begin
                        check("spurious_rvalid", 64'(bmem_rvalid), 64'd0);
                    end else begin
                        cur = sb.pop_front();
                        check("first_beat_cycle", 64'(cyc), 64'(max2(cur.acc + LAT, last_end + 1)));
                        in_burst = 1'b1;
                        mbeat    = 0;
                    end
                end
                if (in_burst) begin
                    check("raddr", 64'(bmem_raddr), 64'(cur.addr));
                    check("rdata", bmem_rdata, cur.line[mbeat*64 +: 64]);
                    if (mbeat == 3) begin
                        in_burst = 1'b0;
                        last_end = cyc;
                    end else begin
                        mbeat++;
                    end
                end
            end else begin
                check("idle_raddr", 64'(bmem_raddr), 64'd0);
                check("idle_rdata", bmem_rdata, 64'd0);
                if (in_burst) begin
                    check("burst_gap", 64'(bmem_rvalid), 64'd1);
                    in_burst = 1'b0;
                end else if (sb.size() > 0 && cyc >= max2(sb[0].acc + LAT, last_end + 1)) begin
                    check("rvalid_late", 64'(bmem_rvalid), 64'd1);
                    void'(sb.pop_front());
                end
            end

            if (mws == 0) begin
                if (bmem_read && bmem_ready && !bmem_write)
                    sb.push_back('{addr: {bmem_addr[31:5], 5'b00000}, line: mmem[bmem_addr[12:5]], acc: cyc});
                if (bmem_write && bmem_ready) begin
                    widx  = bmem_addr[12:5];
                    wb[0] = bmem_wdata;
                    mws   = 1;
                end
            end else if (bmem_write) begin
                if (mws == 3) begin
                    mmem[widx] = {bmem_wdata, wb[2], wb[1], wb[0]};
                    mws = 0;
                end else begin
                    wb[mws] = bmem_wdata;
                    mws++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!bmem_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bmem_ready) check({tag, "_timeout"}, 64'(bmem_ready), 64'd1);
        acc = cyc;
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output int acc);
        bmem_addr = a;
        bmem_read = 1'b1;
        wait_ready("rd_accept", acc);
        bmem_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] d);
        int acc;
        bmem_addr  = a;
        bmem_write = 1'b1;
        bmem_wdata = d[63:0];
        wait_ready("wr_accept", acc);
        for (int k = 1; k < 4; k++) begin
            bmem_wdata = d[k*64 +: 64];
            @(negedge clk);
            check("wr_beat_ready", 64'(bmem_ready), 64'd1);
            tick();
        end
        bmem_write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_ready", 64'(bmem_ready), 64'd0);
        check("rst_rvalid", 64'(bmem_rvalid), 64'd0);
        check("rst_err", 64'(bmem_err), 64'd0);
        check("rst_raddr", 64'(bmem_raddr), 64'd0);
        check("rst_rdata", bmem_rdata, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ready_low_first_cycle", 64'(bmem_ready), 64'd0);
        tick();
        @(negedge clk);
        check("ready_rises", 64'(bmem_ready), 64'd1);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_burst) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin
        int t0, t1, t2, t3, t4, ta, tb;
        int n;
        int nv;
        logic [255:0] pat_a, pat_b, pat_c;

        for (int i = 0; i < 256; i++) mmem[i] = '0;
        tick();
        do_reset();

        // basic read of a never-written line
        do_read(32'h0000_0040, t0);
        drain();
        check("err_after_read", 64'(bmem_err), 64'd0);

        // write then immediate read, plus aliased read
        do_write(32'h1000_0020, {64'h44, 64'h33, 64'h22, 64'h11});
        do_read(32'h1000_0020, t0);
        do_read(32'h0000_0020, t1);
        check("alias_read_b2b", 64'(t1), 64'(t0 + 1));
        drain();

        // queue full: four accepts back-to-back, fifth waits for first pop
        pat_a = {64'hDDDD_0003, 64'hCCCC_0002, 64'hBBBB_0001, 64'hAAAA_0000};
        do_write(32'h0000_0140, pat_a);
        drain();
        do_read(32'h0000_0100, t0);
        do_read(32'h0000_0120, t1);
        do_read(32'h0000_0140, t2);
        do_read(32'h0000_0160, t3);
        check("four_b2b", 64'(t3), 64'(t0 + 3));
        bmem_addr = 32'h0000_0180;
        bmem_read = 1'b1;
        @(negedge clk);
        check("q_full_ready", 64'(bmem_ready), 64'd0);
        wait_ready("rd5", t4);
        bmem_read = 1'b0;
        check("fifth_accept_cycle", 64'(t4), 64'(t0 + LAT + 4));
        drain();

        // snapshot ordering: read before write returns old, read after returns new
        pat_b = {64'h0B03, 64'h0B02, 64'h0B01, 64'h0B00};
        pat_c = {64'h0C03, 64'h0C02, 64'h0C01, 64'h0C00};
        do_write(32'h0000_0200, pat_b);
        do_read(32'h0000_0200, ta);
        do_write(32'h0000_0200, pat_c);
        do_read(32'h0000_0200, tb);
        check("read_after_write_cycle", 64'(tb), 64'(ta + 5));
        drain();
        check("err_still_clear", 64'(bmem_err), 64'd0);

        // protocol errors: read+write together, read pulse in W2
        bmem_addr  = 32'h0000_0300;
        bmem_write = 1'b1;
        bmem_read  = 1'b1;
        bmem_wdata = 64'h3000;
        wait_ready("wr_err", ta);
        bmem_read  = 1'b0;
        bmem_wdata = 64'h3001;
        tick();
        bmem_read  = 1'b1;
        bmem_wdata = 64'h3002;
        tick();
        bmem_read  = 1'b0;
        bmem_wdata = 64'h3003;
        tick();
        bmem_write = 1'b0;
        @(negedge clk);
        check("err_set", 64'(bmem_err), 64'd1);
        repeat (5) tick();
        @(negedge clk);
        check("err_sticky", 64'(bmem_err), 64'd1);
        tick();
        do_read(32'h0000_0300, ta);
        drain();

        // reset during W2 drops the partial write
        do_write(32'h0000_0400, pat_b);
        bmem_addr  = 32'h0000_0400;
        bmem_write = 1'b1;
        bmem_wdata = 64'hDEAD_0000;
        wait_ready("wr_rst", ta);
        bmem_wdata = 64'hDEAD_0001;
        tick();
        bmem_write = 1'b0;
        do_reset();
        do_read(32'h0000_0400, ta);
        drain();

        // reset during a return burst empties the queue
        do_read(32'h0000_0040, ta);
        do_read(32'h0000_0400, tb);
        n = 0;
        @(negedge clk);
        while (!bmem_rvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("burst_seen_before_rst", 64'(bmem_rvalid), 64'd1);
        tick();
        do_reset();
        nv = 0;
        repeat (LAT + 20) begin
            @(negedge clk);
            nv += int'(bmem_rvalid);
        end
        check("queue_empty_after_rst", 64'(nv), 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
